// File: rtl/regfile_write_arbiter.sv
// Register file write-port arbiter.
// A round-robin grant picks one of NUM_REQ write-back sources each cycle. The
// winning write is registered for one cycle before it reaches the array.
// A bypass covers the cycle in which a write sits in that output register.
module regfile_write_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       rf_write_enable,
  output logic [ADDR_W-1:0]          rf_write_address,
  output logic [DATA_W-1:0]          rf_write_data,
  input  logic [ADDR_W-1:0]          byp_read_address_0,
  output logic                       byp_hit_0,
  output logic [DATA_W-1:0]          byp_data_0,
  input  logic [ADDR_W-1:0]          byp_read_address_1,
  output logic                       byp_hit_1,
  output logic [DATA_W-1:0]          byp_data_1
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              found;
  logic [PTR_W-1:0]  grant_idx;
  logic [PTR_W:0]    scan_idx;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // Round-robin scan: first valid requester at or after rr_ptr, wrapping.
  // Grants are suppressed while reset is asserted.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (scan_idx >= (PTR_W+1)'(NUM_REQ)) begin
        scan_idx = scan_idx - (PTR_W+1)'(NUM_REQ);
      end
      if (!found && req_valid[scan_idx[PTR_W-1:0]]) begin
        found     = 1'b1;
        grant_idx = scan_idx[PTR_W-1:0];
      end
    end
    if (!rst_n) begin
      found = 1'b0;
    end
  end

  // One-hot ready decoded from the winning index.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = found && (grant_idx == PTR_W'(i));
    end
  end

  assign sel_addr = req_addr[grant_idx*ADDR_W +: ADDR_W];
  assign sel_data = req_data[grant_idx*DATA_W +: DATA_W];

  // Next-state: pointer moves past the winner, output stage captures the write.
  // Writes to x0 complete the handshake but never enable the array.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    if (found) begin
      rr_ptr_d = (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
      we_d     = (sel_addr != '0);
      addr_d   = sel_addr;
      data_d   = sel_data;
    end
  end

  // State registers; reset drops any write held in the output stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  assign rf_write_enable  = we_q;
  assign rf_write_address = addr_q;
  assign rf_write_data    = data_q;

  // Bypass from the output stage; x0 never hits.
  always_comb begin
    byp_hit_0  = we_q && (addr_q == byp_read_address_0) && (byp_read_address_0 != '0);
    byp_hit_1  = we_q && (addr_q == byp_read_address_1) && (byp_read_address_1 != '0);
    byp_data_0 = byp_hit_0 ? data_q : '0;
    byp_data_1 = byp_hit_1 ? data_q : '0;
  end

endmodule
